scan_move_sequencer: RTL and testbench
======================================

// Module: scan_move_sequencer
// PURPOSE
//  Parametrised successor to the fixed scan-move generator. Steps through the full
//  48-observation sticker scan (24 corner facelets, then 24 edge facelets). Before each
//  observation it emits one packed batch of face-turn codes, with a count and a
//  valid/ack handshake. Sits between determine_state (issues advance) and the motor
//  move queue (consumes moves, acks).
// PARAMETERS
//  MOVE_W     4   bits per move code (0=NOP, R=2,Ri=3,U=4,Ui=5,F=6,Fi=7,L=8,Li=9,B=10,Bi=11,D=12,Di=13)
//  MAX_MOVES  16  move slots in output word; must be >=16 (longest batch); elaboration $error otherwise
//  NUM_OBS    48  observation steps; step indices 0..NUM_OBS-1
//  IDX_W      6   width of step index; must satisfy 2**IDX_W > NUM_OBS
// PORTS
//  clock        in   1                  system clock, all state on posedge
//  reset_n      in   1                  asynchronous active-low reset
//  start        in   1                  pulse: begin scan at step 0 (ignored unless IDLE or DONE)
//  advance      in   1                  pulse: observation done, fetch next step's batch
//  abort        in   1                  pulse: drop everything, return to IDLE
//  moves        out  MAX_MOVES*MOVE_W   packed batch; move k (k=0 executes first) at [k*MOVE_W +: MOVE_W]
//  move_count   out  5                  number of valid moves in batch (0..16)
//  moves_valid  out  1                  batch offered; held until moves_ack
//  moves_ack    in   1                  consumer accepted batch
//  step_idx     out  IDX_W              step the current batch precedes
//  busy         out  1                  high in any state except IDLE/DONE
//  done         out  1                  high in DONE
//  seq_error    out  1                  sticky: advance received outside WAIT_OBS; cleared by start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, step counter 0.
//  FSM: IDLE -start-> LOAD -> OFFER -ack-> WAIT_OBS -advance-> LOAD (step+1)
//       WAIT_OBS on last step + advance -> DONE (or UNDO path, see CONFIGURATION).
//       DONE -start-> LOAD (step 0).
//  LOAD (1 cycle): registered case-ROM lookup by step counter. Unused slots are forced to 0.
//  OFFER: moves, move_count and step_idx are stable, and moves_valid=1.
//         moves_ack with moves_valid transfers; moves_valid drops next cycle.
//  Latency: start/advance at cycle N -> moves_valid=1 at cycle N+2.
//  A batch with move_count=0 (step 0) is still offered and must be acked.
//  ROM batch content (before step s, in execution order):
//    Corners: steps 0..23 in groups of 4; steps 1,2,3 of each group = U.
//    Group openers: 4={U,F,Bi}, 8={U,B,Fi,Li,R}, 12={U,Ri,L,Fi,B},
//                   16={U,Bi,F,L,Ri}, 20={U,Ri,L,R,Li... per scan table}.
//    Edges: steps 24..47 use the same group structure. Each opener = U + undo of the
//      previous group setup + this group's setup (table in scan_tables.vh).
//    Every entry is <=16 moves; half-turns are encoded as two quarter-turns.
//  Simultaneous events:
//    abort has priority over everything; state goes to IDLE and moves_valid drops next cycle.
//    start while busy is ignored.
//    advance in LOAD/OFFER/IDLE/DONE is ignored and sets seq_error.
//    ack without valid is ignored.
//  Step counter saturates at NUM_OBS-1 (no wrap). Async reset mid-handshake clears moves_valid immediately.
// CONFIGURATION
//  SCAN_RESTORE_EN defined: after advance on step NUM_OBS-1, enter LOAD/OFFER once more
//    with step_idx=NUM_OBS and the restore batch {B,B,F,F,L,L,R,R} (count 8). ack -> DONE.
//    This returns the cube to scan-start orientation.
//  Not defined: advance on the last step goes straight to DONE; no restore batch.
//    The cube is left in the edge-scan pose.
// TESTING
//  1 reset_n low then high, start -> 2 cycles later moves_valid=1, step_idx=0, move_count=0, moves=0.
//  2 ack, advance -> step_idx=1, move_count=1, moves[3:0]=4'h4, all upper bits 0.
//  3 walk to step 4 -> move_count=3, moves[11:0]=12'hB64.
//  4 advance while moves_valid=1 -> seq_error=1, batch unchanged; next start clears seq_error.
//  5 abort during OFFER at step 30 -> next cycle IDLE, moves_valid=0, busy=0; start restarts at step 0.
//  6 full run of 48 steps.
//    With SCAN_RESTORE_EN: extra batch step_idx=48, count 8, then done=1.
//    Without it: done=1 one cycle after the final advance.

Source files
------------

// File: rtl/scan_move_sequencer.sv
// ---------------------------------------------------------------------------
// scan_move_sequencer
//
// Purpose:
//   Steps through the 48-observation sticker scan (24 corner facelets, then
//   24 edge facelets). Before each observation it offers one packed batch of
//   face-turn codes to the motor move queue over a valid/ack handshake.
//   determine_state signals each completed observation with `advance`.
//
// Move codes (MOVE_W bits each):
//   0=NOP R=2 Ri=3 U=4 Ui=5 F=6 Fi=7 L=8 Li=9 B=10 Bi=11 D=12 Di=13
//
// Ports:
//   clock        in   system clock, all state on posedge
//   reset_n      in   asynchronous active-low reset
//   start        in   begin scan at step 0 (accepted only in IDLE/DONE)
//   advance      in   observation done, fetch next step's batch
//   abort        in   drop everything, return to IDLE (highest priority)
//   moves        out  packed batch, move k at [k*MOVE_W +: MOVE_W], k=0 first
//   move_count   out  number of valid moves in the batch (0..16)
//   moves_valid  out  batch offered, held until moves_ack
//   moves_ack    in   consumer accepted the batch
//   step_idx     out  step the current batch precedes
//   busy         out  high in any state except IDLE/DONE
//   done         out  high in DONE
//   seq_error    out  sticky: advance seen outside WAIT_OBS; cleared by start
//
// Configuration:
//   SCAN_RESTORE_EN  when defined, one extra batch (step_idx = NUM_OBS,
//                    {B,B,F,F,L,L,R,R}) is offered after the last
//                    observation to return the cube to its scan-start pose.
//                    When undefined, the last advance goes straight to DONE.
// ---------------------------------------------------------------------------
module scan_move_sequencer #(
    parameter int unsigned MOVE_W    = 4,
    parameter int unsigned MAX_MOVES = 16,
    parameter int unsigned NUM_OBS   = 48,
    parameter int unsigned IDX_W     = 6
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        advance,
    input  logic                        abort,
    output logic [MAX_MOVES*MOVE_W-1:0] moves,
    output logic [4:0]                  move_count,
    output logic                        moves_valid,
    input  logic                        moves_ack,
    output logic [IDX_W-1:0]            step_idx,
    output logic                        busy,
    output logic                        done,
    output logic                        seq_error
);

    localparam int unsigned ROM_SLOTS = 16;

    if (MAX_MOVES < ROM_SLOTS) begin : g_bad_max_moves
        $error("scan_move_sequencer: MAX_MOVES must be >= 16");
    end
    if (MOVE_W < 4) begin : g_bad_move_w
        $error("scan_move_sequencer: MOVE_W must be >= 4");
    end
    if ((2 ** IDX_W) <= NUM_OBS) begin : g_bad_idx_w
        $error("scan_move_sequencer: 2**IDX_W must exceed NUM_OBS");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_OFFER,
        S_WAIT_OBS,
        S_DONE
    } state_t;

    state_t                        state;
    logic [IDX_W-1:0]              step_cnt;
    logic [ROM_SLOTS*4-1:0]        rom_word;
    logic [4:0]                    rom_cnt;
    logic [MAX_MOVES*MOVE_W-1:0]   moves_next;
    int unsigned                   step_int;
`ifdef SCAN_RESTORE_EN
    logic                          restore_q;
`endif

    // Batch ROM. Literals hold 4-bit codes with the first move in the lowest
    // nibble, so they read right-to-left in execution order. Slots above the
    // batch length are zero in every literal.
    always_comb begin
        rom_word = '0;
        rom_cnt  = '0;
        step_int = 32'(step_cnt);
        case (step_int)
            0:  begin rom_word = '0;                 rom_cnt = 5'd0; end
            // Corner group openers: U + group setup
            4:  begin rom_word = 64'h0000_0000_0000_0B64; rom_cnt = 5'd3; end
            8:  begin rom_word = 64'h0000_0000_0002_97A4; rom_cnt = 5'd5; end
            12: begin rom_word = 64'h0000_0000_000A_7834; rom_cnt = 5'd5; end
            16: begin rom_word = 64'h0000_0000_0003_86B4; rom_cnt = 5'd5; end
            20: begin rom_word = 64'h0000_0000_0009_2834; rom_cnt = 5'd5; end
            // Edge group openers: U + undo(previous setup) + this setup
            24: begin rom_word = 64'h0000_0000_0662_9384; rom_cnt = 5'd7; end
            28: begin rom_word = 64'h0000_0000_0002_2774; rom_cnt = 5'd5; end
            32: begin rom_word = 64'h0000_0000_000A_A334; rom_cnt = 5'd5; end
            36: begin rom_word = 64'h0000_0000_0008_8BB4; rom_cnt = 5'd5; end
            40: begin rom_word = 64'h0000_0000_000C_C994; rom_cnt = 5'd5; end
            44: begin rom_word = 64'h0000_0000_0002_6DD4; rom_cnt = 5'd5; end
            // Within a group: a single U turn brings the next facelet round
            default: begin rom_word = 64'h0000_0000_0000_0004; rom_cnt = 5'd1; end
        endcase
`ifdef SCAN_RESTORE_EN
        if (restore_q) begin
            rom_word = 64'h0000_0000_2288_66AA;
            rom_cnt  = 5'd8;
        end
`endif
    end

    // Widen each 4-bit ROM code into its MOVE_W slot; slots beyond the ROM
    // width stay zero.
    always_comb begin
        moves_next = '0;
        for (int unsigned k = 0; k < ROM_SLOTS; k++) begin
            moves_next[k*MOVE_W +: MOVE_W] = MOVE_W'(rom_word[k*4 +: 4]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            step_cnt    <= '0;
            moves       <= '0;
            move_count  <= '0;
            moves_valid <= 1'b0;
            step_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            seq_error   <= 1'b0;
`ifdef SCAN_RESTORE_EN
            restore_q   <= 1'b0;
`endif
        end else if (abort) begin
            state       <= S_IDLE;
            step_cnt    <= '0;
            moves_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef SCAN_RESTORE_EN
            restore_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        step_cnt  <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        seq_error <= 1'b0;
`ifdef SCAN_RESTORE_EN
                        restore_q <= 1'b0;
`endif
                    end
                    if (advance) begin
                        seq_error <= 1'b1;
                    end
                end

                S_LOAD: begin
                    moves       <= moves_next;
                    move_count  <= rom_cnt;
                    moves_valid <= 1'b1;
                    state       <= S_OFFER;
`ifdef SCAN_RESTORE_EN
                    step_idx    <= restore_q ? IDX_W'(NUM_OBS) : step_cnt;
`else
                    step_idx    <= step_cnt;
`endif
                    if (advance) begin
                        seq_error <= 1'b1;
                    end
                end

                S_OFFER: begin
                    if (moves_ack && moves_valid) begin
                        moves_valid <= 1'b0;
`ifdef SCAN_RESTORE_EN
                        if (restore_q) begin
                            state     <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            restore_q <= 1'b0;
                        end else begin
                            state <= S_WAIT_OBS;
                        end
`else
                        state <= S_WAIT_OBS;
`endif
                    end
                    if (advance) begin
                        seq_error <= 1'b1;
                    end
                end

                S_WAIT_OBS: begin
                    if (advance) begin
                        if (step_cnt == IDX_W'(NUM_OBS - 1)) begin
                            // Counter saturates here; the scan is complete.
`ifdef SCAN_RESTORE_EN
                            restore_q <= 1'b1;
                            state     <= S_LOAD;
`else
                            state     <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
`endif
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                            state    <= S_LOAD;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_move_sequencer.sv
module tb_scan_move_sequencer;

    localparam int unsigned MOVE_W    = 4;
    localparam int unsigned MAX_MOVES = 16;
    localparam int unsigned NUM_OBS   = 48;
    localparam int unsigned IDX_W     = 6;

    logic                        clock;
    logic                        reset_n;
    logic                        start;
    logic                        advance;
    logic                        abort;
    logic [MAX_MOVES*MOVE_W-1:0] moves;
    logic [4:0]                  move_count;
    logic                        moves_valid;
    logic                        moves_ack;
    logic [IDX_W-1:0]            step_idx;
    logic                        busy;
    logic                        done;
    logic                        seq_error;

    int n_compared;
    int n_mismatched;

    scan_move_sequencer #(
        .MOVE_W   (MOVE_W),
        .MAX_MOVES(MAX_MOVES),
        .NUM_OBS  (NUM_OBS),
        .IDX_W    (IDX_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .advance    (advance),
        .abort      (abort),
        .moves      (moves),
        .move_count (move_count),
        .moves_valid(moves_valid),
        .moves_ack  (moves_ack),
        .step_idx   (step_idx),
        .busy       (busy),
        .done       (done),
        .seq_error  (seq_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Move codes
    localparam int R = 2, RI = 3, U = 4, F = 6, FI = 7, L = 8, LI = 9,
                   B = 10, BI = 11, D = 12;

    // Scan geometry: 12 groups of 4 steps; each group has a setup turn list.
    // Groups 0..5 are corners (opener = U + setup), groups 6..11 are edges
    // (opener = U + inverse of the previous setup + this setup).
    int setup_len [12] = '{0, 2, 4, 4, 4, 4, 2, 2, 2, 2, 2, 2};
    int setup_tab [12][4] = '{
        '{0, 0, 0, 0},
        '{F, BI, 0, 0},
        '{B, FI, LI, R},
        '{RI, L, FI, B},
        '{BI, F, L, RI},
        '{RI, L, R, LI},
        '{F, F, 0, 0},
        '{R, R, 0, 0},
        '{B, B, 0, 0},
        '{L, L, 0, 0},
        '{D, D, 0, 0},
        '{F, R, 0, 0}
    };
    int restore_seq [8] = '{B, B, F, F, L, L, R, R};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void push_move(inout logic [63:0] w, inout int n, input int code);
        w[n*4 +: 4] = 4'(code);
        n++;
    endfunction

    // Reference batch for step s (s == NUM_OBS means the restore batch).
    function automatic void model_batch(input int s, output logic [63:0] w, output int n);
        int g;
        w = '0;
        n = 0;
        if (s == int'(NUM_OBS)) begin
            for (int i = 0; i < 8; i++) push_move(w, n, restore_seq[i]);
            return;
        end
        if (s == 0) return;
        push_move(w, n, U);
        if (s % 4 != 0) return;
        g = s / 4;
        if (g >= 6) begin
            // Inverse: reverse order, flip direction (codes pair as even/odd)
            for (int i = setup_len[g-1] - 1; i >= 0; i--)
                push_move(w, n, setup_tab[g-1][i] ^ 1);
        end
        for (int i = 0; i < setup_len[g]; i++) push_move(w, n, setup_tab[g][i]);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic check_batch(input int s);
        logic [63:0] w;
        int          n;
        model_batch(s, w, n);
        check("step_idx", 64'(step_idx), 64'(s));
        check("move_count", 64'(move_count), 64'(n));
        check("moves", 64'(moves), w);
    endtask

    // Called on the negedge right after the cycle that sampled start/advance.
    task automatic expect_offer(input int s);
        check("latency_n1_valid", 64'(moves_valid), 64'd0);
        @(negedge clock);
        check("latency_n2_valid", 64'(moves_valid), 64'd1);
        check("busy_offer", 64'(busy), 64'd1);
        check_batch(s);
    endtask

    task automatic do_ack();
        int d;
        d = $urandom_range(0, 3);
        cyc(d);
        check("valid_hold", 64'(moves_valid), 64'd1);
        moves_ack = 1'b1;
        @(negedge clock);
        moves_ack = 1'b0;
        check("valid_drop", 64'(moves_valid), 64'd0);
    endtask

    task automatic do_advance();
        int d;
        d = $urandom_range(0, 3);
        cyc(d);
        advance = 1'b1;
        @(negedge clock);
        advance = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset_n      = 1'b0;
        start        = 1'b0;
        advance      = 1'b0;
        abort        = 1'b0;
        moves_ack    = 1'b0;

        // Reset state
        cyc(2);
        check("rst_valid", 64'(moves_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_seq_error", 64'(seq_error), 64'd0);
        check("rst_step_idx", 64'(step_idx), 64'd0);
        check("rst_move_count", 64'(move_count), 64'd0);
        check("rst_moves", 64'(moves), 64'd0);
        reset_n = 1'b1;
        cyc(1);

        // First pass: steps 0..5, then an illegal advance during OFFER
        pulse_start();
        expect_offer(0);
        for (int s = 1; s <= 5; s++) begin
            do_ack();
            do_advance();
            expect_offer(s);
        end
        advance = 1'b1;
        @(negedge clock);
        advance = 1'b0;
        check("err_set", 64'(seq_error), 64'd1);
        check("err_valid_kept", 64'(moves_valid), 64'd1);
        check_batch(5);

        // Walk on to step 30, with a stray ack in WAIT_OBS along the way
        for (int s = 6; s <= 30; s++) begin
            do_ack();
            if (s == 12) begin
                moves_ack = 1'b1;
                @(negedge clock);
                moves_ack = 1'b0;
                check("stray_ack_valid", 64'(moves_valid), 64'd0);
                check("stray_ack_busy", 64'(busy), 64'd1);
            end
            do_advance();
            expect_offer(s);
        end

        // Abort during OFFER
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_valid", 64'(moves_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_err_sticky", 64'(seq_error), 64'd1);
        cyc(2);

        // Restart: clears seq_error, begins at step 0, then full run
        pulse_start();
        check("start_clears_err", 64'(seq_error), 64'd0);
        expect_offer(0);
        for (int s = 1; s < int'(NUM_OBS); s++) begin
            do_ack();
            do_advance();
            expect_offer(s);
        end
        do_ack();
        do_advance();
`ifdef SCAN_RESTORE_EN
        check("restore_not_done", 64'(done), 64'd0);
        expect_offer(int'(NUM_OBS));
        do_ack();
`endif
        check("final_done", 64'(done), 64'd1);
        check("final_busy", 64'(busy), 64'd0);
        check("final_valid", 64'(moves_valid), 64'd0);
        check("final_err", 64'(seq_error), 64'd0);

        // Advance in DONE is an error; start from DONE restarts at step 0
        advance = 1'b1;
        @(negedge clock);
        advance = 1'b0;
        check("done_adv_err", 64'(seq_error), 64'd1);
        check("done_held", 64'(done), 64'd1);
        pulse_start();
        check("restart_done_clr", 64'(done), 64'd0);
        check("restart_err_clr", 64'(seq_error), 64'd0);
        expect_offer(0);
        do_ack();
        do_advance();
        expect_offer(1);

        // Asynchronous reset mid-handshake
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(moves_valid), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_step", 64'(step_idx), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        cyc(2);
        check("post_rst_valid", 64'(moves_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
